lsu_store_buffer: RTL and testbench
===================================

# lsu_store_buffer

Parametrised store buffer and load port for the load/store unit, sitting between the LSU datapath and the data-memory interface. It queues committed stores in a DEPTH-entry circular FIFO, drains them to memory in order under a write-ready handshake, and services one load at a time. A load is forwarded from the youngest matching buffered store or, failing that, read from memory. This adds multi-entry buffering, write backpressure and store-to-load forwarding to the single-request LSU memory path.

## Interface
- DATA_BITS, 64, width of load/store data and of a memory word
- ADDR_BITS, 64, address width; addresses are word-aligned, and the low log2(DATA_BITS/8) bits are ignored for matching
- DEPTH, 4, store-buffer entries; a power of two, at least 2
- INST_ID_BITS, 6, width of the load instruction tag
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-low reset
- st_valid  in  1  committed store offered
- st_ready  out  1  buffer can accept a store
- st_addr  in  ADDR_BITS  store address
- st_data  in  DATA_BITS  store data
- ld_valid  in  1  load offered
- ld_ready  out  1  load port idle
- ld_addr  in  ADDR_BITS  load address
- ld_inst_id  in  INST_ID_BITS  load tag
- ld_out_valid  out  1  one-cycle load result strobe; no backpressure
- ld_out_data  out  DATA_BITS  load result
- ld_out_inst_id  out  INST_ID_BITS  tag of the result
- ld_out_fwd  out  1  result came from the buffer
- sb_empty  out  1  no buffered stores, used by fences
- mem_ren  out  1  memory read request, one-cycle pulse
- mem_raddr  out  ADDR_BITS  read address
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_BITS  read data
- mem_wen  out  1  write request
- mem_waddr  out  ADDR_BITS  write address
- mem_wdata  out  DATA_BITS  write data
- mem_wready  in  1  memory accepts the write this cycle

## Operation
- **Store FIFO.** Head and tail pointers of log2(DEPTH) bits each, wrapping modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
  - A store is accepted when st_valid && st_ready. It is written at tail and tail advances.
  - st_ready = (count != DEPTH). When the buffer is full, a same-cycle drain does not enable an accept.
- **Drain.** When count != 0: mem_wen = 1, with mem_waddr/mem_wdata taken from the head entry. The head retires on mem_wen && mem_wready. An accept and a retire in the same cycle leave count unchanged.
- **Load FSM** (states IDLE, ISSUE, WAIT, RESP):
  - IDLE: ld_ready = 1. On ld_valid, latch addr and id and search all valid entries plus the store being accepted that cycle. The same-cycle store counts as older than the load and is the youngest candidate. The youngest match in program order (nearest tail) wins.
    - Hit: latch that entry's data, set fwd = 1, go to RESP.
    - Miss: go to ISSUE.
  - ISSUE: mem_ren = 1 and mem_raddr = the latched addr, for exactly one cycle; then go to WAIT.
  - WAIT: on mem_rvalid, latch mem_rdata with fwd = 0 and go to RESP. mem_rvalid is ignored in every state other than WAIT.
  - RESP: ld_out_valid = 1, driving the latched data, id and fwd; then go to IDLE.
- The entry being drained in the lookup cycle is still valid and can be forwarded.
- The memory contract is: a read issued after a write completes returns the new data; a same-cycle read and write return the old data. A missing load has no older matching store, so this ordering is correct.
- sb_empty = (count == 0).
- **Reset** (rst = 0 at a clock edge), including mid-operation:
  - pointers and count are cleared and all entries invalidated; buffered stores are discarded;
  - the FSM goes to IDLE;
  - outputs after reset: st_ready = 1, ld_ready = 1, sb_empty = 1; ld_out_valid, mem_ren and mem_wen are 0; all data, address and id outputs are 0.
  - An outstanding mem_rvalid arriving after reset is ignored.

## Timing
- Store accepted at cycle t: it is visible on mem_wen at t+1 at the earliest and retires on the first cycle with mem_wready = 1.
- Forwarded load accepted at t: ld_out_valid at t+1.
- Missing load accepted at t: mem_ren at t+1, then ld_out_valid one cycle after mem_rvalid.
- Next load accept: the cycle after RESP at the earliest.
- st_ready, ld_ready, mem_wen and sb_empty depend only on registered state, with no combinational path from inputs.
- The match logic is combinational from ld_addr and st_addr to the FSM next-state.

## Structure
- Package lsu_pkg holds:
  - sb_entry_t: valid, addr, data;
  - ld_state_e: IDLE, ISSUE, WAIT, RESP;
  - localparam helpers PTR_BITS and OFFSET_BITS.
- Sub-module sb_youngest_match:
  - inputs: the entries, head, tail, the incoming store and the lookup address;
  - outputs: a hit flag and the selected data, via a rotated priority encoder from the tail.

## Test plan
- **Reset state.** After reset: st_ready = 1, ld_ready = 1, sb_empty = 1, mem_wen = 0.
- **Fill and backpressure.** With mem_wready = 0, offer 5 stores to 0x100..0x140 → 4 are accepted and st_ready = 0. Raise mem_wready → writes appear in order 0x100..0x130, one per cycle, and sb_empty = 1 after the 4th.
- **Youngest-match forwarding.** Buffer stores 0x200←0xAA then 0x200←0xBB with the drain stalled, then load 0x200 with id 5 → ld_out_valid one cycle later with data 0xBB, id 5, fwd = 1.
- **Load miss.** Load 0x300 with an empty buffer → mem_ren one cycle later with mem_raddr = 0x300. Memory returns 0x1234 with a 3-cycle latency → ld_out_valid one cycle after mem_rvalid with fwd = 0.
- **Simultaneous store and load.** Store 0x400←0x77 and load 0x400 in the same cycle → forwarded 0x77. Also run tail wrap-around after 6 accepts and 6 drains, with forwarding still correct.
- **Reset mid-operation.** Assert rst while in WAIT with 3 stores buffered → sb_empty = 1 and no mem_wen. A late mem_rvalid produces no ld_out_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and sizing helpers for the LSU store buffer and its match logic.
package lsu_pkg;

    localparam int unsigned SB_DATA_BITS = 64;
    localparam int unsigned SB_ADDR_BITS = 64;
    localparam int unsigned SB_DEPTH     = 4;

    function automatic int unsigned ptr_bits(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned offset_bits(input int unsigned data_bits);
        return $clog2(data_bits / 8);
    endfunction

    localparam int unsigned PTR_BITS    = ptr_bits(SB_DEPTH);
    localparam int unsigned OFFSET_BITS = offset_bits(SB_DATA_BITS);

    typedef struct packed {
        logic                    valid;
        logic [SB_ADDR_BITS-1:0] addr;
        logic [SB_DATA_BITS-1:0] data;
    } sb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } ld_state_e;

endpackage

// File: rtl/sb_youngest_match.sv
// Youngest-store lookup: rotated priority scan from tail back to head, with the
// store being accepted this cycle taking precedence over every buffered entry.
module sb_youngest_match
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH  = SB_DEPTH,
    parameter int unsigned OFFSET = OFFSET_BITS,
    localparam int unsigned PW    = ptr_bits(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0]   entries,
    input  logic [PW-1:0]           head,
    input  logic [PW-1:0]           tail,
    input  logic                    st_fire,
    input  logic [SB_ADDR_BITS-1:0] st_addr,
    input  logic [SB_DATA_BITS-1:0] st_data,
    input  logic [SB_ADDR_BITS-1:0] lookup_addr,
    output logic                    hit_c,
    output logic [SB_DATA_BITS-1:0] data_c
);

    logic [PW-1:0] idx;
    logic          done;

    function automatic logic word_match(input logic [SB_ADDR_BITS-1:0] a,
                                        input logic [SB_ADDR_BITS-1:0] b);
        return ((a ^ b) >> OFFSET) == '0;
    endfunction

    always_comb begin
        hit_c  = 1'b0;
        data_c = '0;
        done   = 1'b0;
        idx    = tail;
        if (st_fire && word_match(st_addr, lookup_addr)) begin
            hit_c  = 1'b1;
            data_c = st_data;
        end
        // Walk youngest to oldest; the scan never looks past the head slot.
        for (int k = 1; k <= int'(DEPTH); k++) begin
            idx = tail - PW'(k);
            if (!hit_c && !done && entries[idx].valid &&
                word_match(entries[idx].addr, lookup_addr)) begin
                hit_c  = 1'b1;
                data_c = entries[idx].data;
            end
            if (idx == head) begin
                done = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsu_store_buffer.sv
// Store buffer with in-order write drain and a single-outstanding load port that
// forwards from the youngest matching buffered store or reads memory on a miss.
module lsu_store_buffer
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_BITS    = SB_DATA_BITS,
    parameter int unsigned ADDR_BITS    = SB_ADDR_BITS,
    parameter int unsigned DEPTH        = SB_DEPTH,
    parameter int unsigned INST_ID_BITS = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    st_valid,
    output logic                    st_ready,
    input  logic [ADDR_BITS-1:0]    st_addr,
    input  logic [DATA_BITS-1:0]    st_data,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [ADDR_BITS-1:0]    ld_addr,
    input  logic [INST_ID_BITS-1:0] ld_inst_id,
    output logic                    ld_out_valid,
    output logic [DATA_BITS-1:0]    ld_out_data,
    output logic [INST_ID_BITS-1:0] ld_out_inst_id,
    output logic                    ld_out_fwd,
    output logic                    sb_empty,
    output logic                    mem_ren,
    output logic [ADDR_BITS-1:0]    mem_raddr,
    input  logic                    mem_rvalid,
    input  logic [DATA_BITS-1:0]    mem_rdata,
    output logic                    mem_wen,
    output logic [ADDR_BITS-1:0]    mem_waddr,
    output logic [DATA_BITS-1:0]    mem_wdata,
    input  logic                    mem_wready
);

    localparam int unsigned PW = ptr_bits(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = offset_bits(DATA_BITS);

    sb_entry_t [DEPTH-1:0]   entries_q, entries_d;
    logic [PW-1:0]           head_q, head_d;
    logic [PW-1:0]           tail_q, tail_d;
    logic [CW-1:0]           count_q, count_d;
    ld_state_e               state_q, state_d;
    logic [ADDR_BITS-1:0]    ld_addr_q, ld_addr_d;
    logic [INST_ID_BITS-1:0] ld_id_q, ld_id_d;
    logic [DATA_BITS-1:0]    ld_data_q, ld_data_d;
    logic                    ld_fwd_q, ld_fwd_d;

    logic                    st_fire;
    logic                    wr_fire;
    logic                    hit_c;
    logic [SB_DATA_BITS-1:0] match_data_c;

    assign st_ready = (count_q != CW'(DEPTH));
    assign sb_empty = (count_q == '0);
    assign st_fire  = st_valid && st_ready;
    assign wr_fire  = mem_wen && mem_wready;

    sb_youngest_match #(
        .DEPTH  (DEPTH),
        .OFFSET (OW)
    ) u_match (
        .entries     (entries_q),
        .head        (head_q),
        .tail        (tail_q),
        .st_fire     (st_fire),
        .st_addr     (SB_ADDR_BITS'(st_addr)),
        .st_data     (SB_DATA_BITS'(st_data)),
        .lookup_addr (SB_ADDR_BITS'(ld_addr)),
        .hit_c       (hit_c),
        .data_c      (match_data_c)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            ld_addr_q <= '0;
            ld_id_q   <= '0;
            ld_data_q <= '0;
            ld_fwd_q  <= 1'b0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            state_q   <= state_d;
            ld_addr_q <= ld_addr_d;
            ld_id_q   <= ld_id_d;
            ld_data_q <= ld_data_d;
            ld_fwd_q  <= ld_fwd_d;
        end
    end

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        state_d   = state_q;
        ld_addr_d = ld_addr_q;
        ld_id_d   = ld_id_q;
        ld_data_d = ld_data_q;
        ld_fwd_d  = ld_fwd_q;

        // Accept and retire never touch the same slot: that needs full or empty.
        if (st_fire) begin
            entries_d[tail_q] = '{valid: 1'b1,
                                  addr:  SB_ADDR_BITS'(st_addr),
                                  data:  SB_DATA_BITS'(st_data)};
            tail_d = tail_q + PW'(1);
        end
        if (wr_fire) begin
            entries_d[head_q].valid = 1'b0;
            head_d = head_q + PW'(1);
        end
        count_d = count_q + CW'(st_fire) - CW'(wr_fire);

        case (state_q)
            IDLE: begin
                if (ld_valid) begin
                    ld_addr_d = ld_addr;
                    ld_id_d   = ld_inst_id;
                    if (hit_c) begin
                        ld_data_d = DATA_BITS'(match_data_c);
                        ld_fwd_d  = 1'b1;
                        state_d   = RESP;
                    end else begin
                        ld_fwd_d  = 1'b0;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mem_rvalid) begin
                    ld_data_d = mem_rdata;
                    ld_fwd_d  = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ld_ready       = (state_q == IDLE);
    assign ld_out_valid   = (state_q == RESP);
    assign ld_out_data    = ld_out_valid ? ld_data_q : '0;
    assign ld_out_inst_id = ld_out_valid ? ld_id_q : '0;
    assign ld_out_fwd     = ld_out_valid && ld_fwd_q;
    assign mem_ren        = (state_q == ISSUE);
    assign mem_raddr      = mem_ren ? ld_addr_q : '0;
    assign mem_wen        = !sb_empty;
    assign mem_waddr      = mem_wen ? ADDR_BITS'(entries_q[head_q].addr) : '0;
    assign mem_wdata      = mem_wen ? DATA_BITS'(entries_q[head_q].data) : '0;

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Bench for lsu_store_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_lsu_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [63:0] ld_addr;
    logic [5:0]  ld_inst_id;
    logic        ld_out_valid;
    logic [63:0] ld_out_data;
    logic [5:0]  ld_out_inst_id;
    logic        ld_out_fwd;
    logic        sb_empty;
    logic        mem_ren;
    logic [63:0] mem_raddr;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_wen;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic        mem_wready;

    lsu_store_buffer #(
        .DATA_BITS    (64),
        .ADDR_BITS    (64),
        .DEPTH        (DEPTH),
        .INST_ID_BITS (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_addr        (ld_addr),
        .ld_inst_id     (ld_inst_id),
        .ld_out_valid   (ld_out_valid),
        .ld_out_data    (ld_out_data),
        .ld_out_inst_id (ld_out_inst_id),
        .ld_out_fwd     (ld_out_fwd),
        .sb_empty       (sb_empty),
        .mem_ren        (mem_ren),
        .mem_raddr      (mem_raddr),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .mem_wen        (mem_wen),
        .mem_waddr      (mem_waddr),
        .mem_wdata      (mem_wdata),
        .mem_wready     (mem_wready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit word_eq(input logic [63:0] a, input logic [63:0] b);
        return (a >> 3) == (b >> 3);
    endfunction

    // Reference model: buffered stores in program order plus the pending load.
    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } st_t;

    st_t         sbq[$];
    logic [63:0] wr_log[$];
    bit          live = 1'b0;
    bit          m_busy, m_ren_due, m_wait, m_resp, m_fwd;
    bit          m_st_acc, m_wr_ret, m_hit;
    logic [63:0] m_data, m_raddr;
    logic [5:0]  m_id;

    always @(posedge clk) begin
        if (!rst) begin
            sbq.delete();
            m_busy = 0; m_ren_due = 0; m_wait = 0; m_resp = 0; m_fwd = 0;
            live = 1'b1;
        end else if (live) begin
            m_st_acc = st_valid && (sbq.size() < DEPTH);
            m_wr_ret = (sbq.size() != 0) && mem_wready;
            if (m_resp) begin
                m_resp = 0;
                m_busy = 0;
            end else if (m_ren_due) begin
                m_ren_due = 0;
                m_wait    = 1;
            end else if (m_wait) begin
                if (mem_rvalid) begin
                    m_wait = 0; m_resp = 1; m_data = mem_rdata; m_fwd = 0;
                end
            end else if (ld_valid) begin
                m_busy  = 1;
                m_id    = ld_inst_id;
                m_raddr = ld_addr;
                m_hit   = 0;
                if (m_st_acc && word_eq(st_addr, ld_addr)) begin
                    m_hit  = 1;
                    m_data = st_data;
                end
                for (int i = sbq.size() - 1; i >= 0; i--) begin
                    if (!m_hit && word_eq(sbq[i].addr, ld_addr)) begin
                        m_hit  = 1;
                        m_data = sbq[i].data;
                    end
                end
                if (m_hit) begin
                    m_resp = 1; m_fwd = 1;
                end else begin
                    m_ren_due = 1;
                end
            end
            if (m_wr_ret) void'(sbq.pop_front());
            if (m_st_acc) sbq.push_back('{st_addr, st_data});
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("st_ready", 64'(st_ready), 64'(sbq.size() < DEPTH));
            chk("sb_empty", 64'(sb_empty), 64'(sbq.size() == 0));
            chk("mem_wen", 64'(mem_wen), 64'(sbq.size() != 0));
            if (sbq.size() != 0) begin
                chk("mem_waddr", mem_waddr, sbq[0].addr);
                chk("mem_wdata", mem_wdata, sbq[0].data);
            end
            chk("ld_ready", 64'(ld_ready), 64'(!m_busy));
            chk("mem_ren", 64'(mem_ren), 64'(m_ren_due));
            if (m_ren_due) chk("mem_raddr", mem_raddr, m_raddr);
            chk("ld_out_valid", 64'(ld_out_valid), 64'(m_resp));
            if (m_resp) begin
                chk("ld_out_data", ld_out_data, m_data);
                chk("ld_out_inst_id", 64'(ld_out_inst_id), 64'(m_id));
                chk("ld_out_fwd", 64'(ld_out_fwd), 64'(m_fwd));
            end
            if (mem_wen && mem_wready) wr_log.push_back(mem_waddr);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        rst = 1'b0; st_valid = 0; st_addr = '0; st_data = '0;
        ld_valid = 0; ld_addr = '0; ld_inst_id = '0;
        mem_rvalid = 0; mem_rdata = '0; mem_wready = 0;

        // Reset state
        step(); step();
        chk("rst_st_ready", 64'(st_ready), 64'd1);
        chk("rst_ld_ready", 64'(ld_ready), 64'd1);
        chk("rst_sb_empty", 64'(sb_empty), 64'd1);
        chk("rst_mem_wen", 64'(mem_wen), 64'd0);
        rst = 1'b1;
        step();

        // Fill with drain stalled, then drain in order
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            st_valid = 1; st_addr = 64'h100 + 64'(16 * i); st_data = 64'hD0 + 64'(i);
            if (st_ready) acc++;
            step();
        end
        st_valid = 0;
        chk("fill_accepts", 64'(acc), 64'd4);
        chk("full_st_ready", 64'(st_ready), 64'd0);
        chk("full_head_addr", mem_waddr, 64'h100);
        wr_log.delete();
        mem_wready = 1;
        repeat (4) step();
        chk("drain_count", 64'(wr_log.size()), 64'd4);
        if (wr_log.size() == 4) begin
            chk("drain_0", wr_log[0], 64'h100);
            chk("drain_1", wr_log[1], 64'h110);
            chk("drain_2", wr_log[2], 64'h120);
            chk("drain_3", wr_log[3], 64'h130);
        end
        chk("drain_empty", 64'(sb_empty), 64'd1);

        // Youngest-match forwarding
        mem_wready = 0;
        st_valid = 1; st_addr = 64'h200; st_data = 64'hAA; step();
        st_data = 64'hBB; step();
        st_valid = 0;
        ld_valid = 1; ld_addr = 64'h200; ld_inst_id = 6'd5;
        step();
        ld_valid = 0;
        chk("fwd_valid", 64'(ld_out_valid), 64'd1);
        chk("fwd_data", ld_out_data, 64'hBB);
        chk("fwd_id", 64'(ld_out_inst_id), 64'd5);
        chk("fwd_flag", 64'(ld_out_fwd), 64'd1);
        step();
        chk("fwd_ld_ready_after", 64'(ld_ready), 64'd1);
        mem_wready = 1;
        repeat (2) step();

        // Load miss with 3-cycle memory latency
        ld_valid = 1; ld_addr = 64'h300; ld_inst_id = 6'd9;
        step();
        ld_valid = 0;
        chk("miss_ren", 64'(mem_ren), 64'd1);
        chk("miss_raddr", mem_raddr, 64'h300);
        step();
        chk("miss_ren_once", 64'(mem_ren), 64'd0);
        step();
        step();
        mem_rvalid = 1; mem_rdata = 64'h1234;
        step();
        mem_rvalid = 0; mem_rdata = '0;
        chk("miss_valid", 64'(ld_out_valid), 64'd1);
        chk("miss_data", ld_out_data, 64'h1234);
        chk("miss_id", 64'(ld_out_inst_id), 64'd9);
        chk("miss_fwd", 64'(ld_out_fwd), 64'd0);
        step();
        // Stray read data while idle is ignored
        mem_rvalid = 1; mem_rdata = 64'hDEAD;
        step();
        mem_rvalid = 0; mem_rdata = '0;
        chk("stray_rvalid", 64'(ld_out_valid), 64'd0);

        // Same-cycle store and load
        st_valid = 1; st_addr = 64'h400; st_data = 64'h77;
        ld_valid = 1; ld_addr = 64'h400; ld_inst_id = 6'd3;
        step();
        st_valid = 0; ld_valid = 0;
        chk("same_cyc_valid", 64'(ld_out_valid), 64'd1);
        chk("same_cyc_data", ld_out_data, 64'h77);
        chk("same_cyc_fwd", 64'(ld_out_fwd), 64'd1);
        repeat (2) step();

        // Pointer wrap: six pass-through stores, then refill across the wrap
        for (int i = 0; i < 6; i++) begin
            st_valid = 1; st_addr = 64'h500 + 64'(16 * i); st_data = 64'h50 + 64'(i);
            step();
        end
        st_valid = 0;
        step();
        chk("wrap_empty", 64'(sb_empty), 64'd1);
        mem_wready = 0;
        st_valid = 1;
        st_addr = 64'h600; st_data = 64'hC1; step();
        st_addr = 64'h610; st_data = 64'hC2; step();
        st_addr = 64'h600; st_data = 64'hC3; step();
        st_addr = 64'h620; st_data = 64'hC4; step();
        st_valid = 0;
        chk("wrap_full", 64'(st_ready), 64'd0);
        ld_valid = 1; ld_addr = 64'h607; ld_inst_id = 6'd7;
        step();
        ld_valid = 0;
        chk("wrap_fwd_data", ld_out_data, 64'hC3);
        chk("wrap_fwd_flag", 64'(ld_out_fwd), 64'd1);
        step();
        ld_valid = 1; ld_addr = 64'h613; ld_inst_id = 6'd8;
        step();
        ld_valid = 0;
        chk("wrap_fwd2_data", ld_out_data, 64'hC2);
        chk("wrap_fwd2_id", 64'(ld_out_inst_id), 64'd8);
        step();
        wr_log.delete();
        mem_wready = 1;
        repeat (4) step();
        chk("wrap_drain_count", 64'(wr_log.size()), 64'd4);
        if (wr_log.size() == 4) chk("wrap_drain_last", wr_log[3], 64'h620);

        // Reset while a miss is waiting with three stores buffered
        mem_wready = 0;
        st_valid = 1;
        st_addr = 64'h900; st_data = 64'h1; step();
        st_addr = 64'h910; st_data = 64'h2; step();
        st_addr = 64'h920; st_data = 64'h3;
        ld_valid = 1; ld_addr = 64'h800; ld_inst_id = 6'd11;
        step();
        st_valid = 0; ld_valid = 0;
        step();
        chk("pre_rst_ld_ready", 64'(ld_ready), 64'd0);
        chk("pre_rst_wen", 64'(mem_wen), 64'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_rst_sb_empty", 64'(sb_empty), 64'd1);
        chk("mid_rst_wen", 64'(mem_wen), 64'd0);
        chk("mid_rst_ld_ready", 64'(ld_ready), 64'd1);
        chk("mid_rst_waddr", mem_waddr, 64'h0);
        mem_rvalid = 1; mem_rdata = 64'hBAD;
        step();
        mem_rvalid = 0; mem_rdata = '0;
        chk("late_rvalid", 64'(ld_out_valid), 64'd0);
        wr_log.delete();
        mem_wready = 1;
        repeat (3) step();
        chk("post_rst_no_writes", 64'(wr_log.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
